// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter that gives two requesters access to one single-port data memory.
// Each access takes IDLE/RESP -> ACCESS (grant, memory enable) -> RESP (done, read data, range error).
module data_mem_arbiter #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_active,
    output logic              mem_rw,
    output logic [31:0]       mem_index,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d, win_q, win_d, rw_q, rw_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              arb, any, win, in_range, resp;

    // win/last: 0 = a, 1 = b; on a tie the requester not granted last wins
    assign arb = state_q != ACCESS;
    assign any = a_req || b_req;
    assign win = (a_req && b_req) ? !last_q : b_req;

    always_comb begin
        state_d = arb ? (any ? ACCESS : IDLE) : RESP;
        last_d  = last_q;
        win_d   = win_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (arb && any) begin
            last_d  = win;
            win_d   = win;
            rw_d    = win ? b_rw : a_rw;
            addr_d  = win ? b_addr : a_addr;
            wdata_d = win ? b_wdata : a_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // everything below decodes registered state, so reset clears it without waiting for a clock
    assign in_range   = addr_q < 32'(DEPTH);
    assign resp       = state_q == RESP;
    assign busy       = state_q != IDLE;
    assign mem_active = state_q == ACCESS && in_range;
    assign mem_rw     = busy && rw_q;
    assign mem_index  = busy ? addr_q : '0;
    assign mem_wdata  = busy ? wdata_q : '0;
    assign a_gnt      = state_q == ACCESS && !win_q;
    assign b_gnt      = state_q == ACCESS && win_q;
    assign a_done     = resp && !win_q;
    assign b_done     = resp && win_q;
    assign a_err      = a_done && !in_range;
    assign b_err      = b_done && !in_range;
    assign a_rdata    = (a_done && !rw_q && in_range) ? mem_rdata : '0;
    assign b_rdata    = (b_done && !rw_q && in_range) ? mem_rdata : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: drives data_mem_arbiter against a memory device and a transaction-level reference model.
module tb_data_mem_arbiter;
    localparam int DEPTH = 512;

    logic        clk = 0, rst_n = 0;
    logic        a_req = 0, a_rw = 0, b_req = 0, b_rw = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_active, mem_rw, busy;
    logic [31:0] a_rdata, b_rdata, mem_index, mem_wdata;
    logic [31:0] mem_rdata = 0;
    bit   [31:0] dev_mem [DEPTH];
    int          n_cmp = 0, n_bad = 0;
    bit          mon_en = 0;

    typedef struct { bit rw; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { int who; bit rw; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; bit exp_err; } vec_t;

    bit   [31:0] ref_mem [DEPTH];
    int          gnt_who = -1, done_who = -1, last_who = 1;
    txn_t        gnt_t, done_t;
    logic [31:0] done_val = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .mem_active(mem_active), .mem_rw(mem_rw), .mem_index(mem_index),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // the external memory: samples on the rising edge, read data appears the following cycle
    always @(posedge clk) if (mem_active) begin
        if (mem_rw) dev_mem[mem_index[8:0]] <= mem_wdata;
        else mem_rdata <= dev_mem[mem_index[8:0]];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: whoever was granted last cycle completes now; an edge with no grant pending arbitrates
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            gnt_who = -1; done_who = -1; last_who = 1;
        end else begin
            done_who = gnt_who;
            done_t = gnt_t;
            done_val = 0;
            if (gnt_who >= 0 && gnt_t.addr < DEPTH) begin
                if (gnt_t.rw) ref_mem[gnt_t.addr[8:0]] = gnt_t.wdata;
                else done_val = ref_mem[gnt_t.addr[8:0]];
            end
            if (gnt_who >= 0) gnt_who = -1;
            else if (a_req || b_req) begin
                gnt_who = (a_req && b_req) ? 1 - last_who : (a_req ? 0 : 1);
                last_who = gnt_who;
                if (gnt_who == 0) begin gnt_t.rw = a_rw; gnt_t.addr = a_addr; gnt_t.wdata = a_wdata; end
                else begin gnt_t.rw = b_rw; gnt_t.addr = b_addr; gnt_t.wdata = b_wdata; end
            end
        end
    end

    task automatic check_outputs();
        bit g, d;
        logic [31:0] rd;
        txn_t t;
        g = gnt_who >= 0;
        d = done_who >= 0;
        rd = (d && !done_t.rw && done_t.addr < DEPTH) ? done_val : 0;
        t = g ? gnt_t : done_t;
        chk("busy", busy, g || d);
        chk("a_gnt", a_gnt, gnt_who == 0);
        chk("b_gnt", b_gnt, gnt_who == 1);
        chk("a_done", a_done, done_who == 0);
        chk("b_done", b_done, done_who == 1);
        chk("a_err", a_err, done_who == 0 && done_t.addr >= DEPTH);
        chk("b_err", b_err, done_who == 1 && done_t.addr >= DEPTH);
        chk("a_rdata", a_rdata, done_who == 0 ? rd : 0);
        chk("b_rdata", b_rdata, done_who == 1 ? rd : 0);
        chk("mem_active", mem_active, g && gnt_t.addr < DEPTH);
        chk("mem_rw", mem_rw, (g || d) ? t.rw : 0);
        chk("mem_index", mem_index, (g || d) ? t.addr : 0);
        chk("mem_wdata", mem_wdata, (g || d) ? t.wdata : 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) check_outputs();
    end

    task automatic set_req(int who, bit req, bit rw, logic [31:0] addr, logic [31:0] wdata);
        if (who == 0) begin a_req = req; a_rw = rw; a_addr = addr; a_wdata = wdata; end
        else begin b_req = req; b_rw = rw; b_addr = addr; b_wdata = wdata; end
    endtask

    task automatic xfer(int who, bit rw, logic [31:0] addr, logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
        int k;
        k = 0;
        @(negedge clk);
        set_req(who, 1, rw, addr, wdata);
        do begin @(negedge clk); k++; end while (!(who != 0 ? b_gnt : a_gnt) && k < 10);
        chk("gnt_latency", k, 1);
        set_req(who, 0, 0, 0, 0);
        @(negedge clk);
        chk("done_after_gnt", who != 0 ? b_done : a_done, 1);
        rd = who != 0 ? b_rdata : a_rdata;
        er = who != 0 ? b_err : a_err;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(3, 0))
            0, 1: return 32'($urandom_range(15, 0));
            2: return $urandom_range(1, 0) != 0 ? 32'd511 : 32'd512;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        vec_t vecs[10];
        logic [31:0] rd;
        logic er;
        int ag, ad, bg, bd;
        txn_t pend[2];
        bit has[2];

        vecs[0] = '{0, 1, 5, 32'hDEADBEEF, 0, 0};
        vecs[1] = '{0, 0, 5, 0, 32'hDEADBEEF, 0};
        vecs[2] = '{1, 0, 512, 0, 0, 1};
        vecs[3] = '{0, 1, 511, 32'hCAFE55AA, 0, 0};
        vecs[4] = '{0, 0, 511, 0, 32'hCAFE55AA, 0};
        vecs[5] = '{1, 1, 0, 32'h11111111, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 32'h11111111, 0};
        vecs[7] = '{1, 1, 32'hFFFFFFFF, 32'h99, 0, 1};
        vecs[8] = '{1, 0, 0, 0, 32'h11111111, 0};
        vecs[9] = '{1, 0, 3, 0, 0, 0};

        mon_en = 1;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_mem_active", mem_active, 0);

        // tie on the first edge after reset release: a first, b at a's RESP edge
        rst_n = 1;
        set_req(0, 1, 0, 0, 0);
        set_req(1, 1, 0, 1, 0);
        ag = -1; ad = -1; bg = -1; bd = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (a_gnt) begin ag = i; set_req(0, 0, 0, 0, 0); end
            if (b_gnt) begin bg = i; set_req(1, 0, 0, 0, 0); end
            if (a_done) ad = i;
            if (b_done) bd = i;
        end
        chk("tie_a_gnt_cycle", ag, 1);
        chk("tie_a_done_cycle", ad, 2);
        chk("tie_b_gnt_cycle", bg, 3);
        chk("tie_b_done_cycle", bd, 4);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // both held high: grants alternate a,b,... one every 2 cycles
        @(negedge clk);
        set_req(0, 1, 0, 2, 0);
        set_req(1, 1, 0, 3, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("alt_a_gnt", a_gnt, i % 4 == 0);
            chk("alt_b_gnt", b_gnt, i % 4 == 2);
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            xfer(vecs[i].who, vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, er);
            chk("vec_rdata", rd, vecs[i].exp_rd);
            chk("vec_err", er, vecs[i].exp_err);
        end

        // reset in the ACCESS cycle of a write must kill the write and its done
        @(negedge clk);
        set_req(0, 1, 1, 7, 32'h1234);
        @(negedge clk);
        chk("rst_pre_gnt", a_gnt, 1);
        chk("rst_pre_active", mem_active, 1);
        set_req(0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("rst_async_active", mem_active, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_gnt", a_gnt, 0);
        chk("rst_async_index", mem_index, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", a_done, 0);
        end
        xfer(0, 0, 7, 0, rd, er);
        chk("rst_read7", rd, 0);
        chk("rst_read7_err", er, 0);

        // random traffic: requesters hold until granted, then drop or issue the next request
        has[0] = 0; has[1] = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                if (has[w] && gnt_who == w) has[w] = 0;
                if (!has[w] && $urandom_range(1, 0) != 0) begin
                    has[w] = 1;
                    pend[w].rw = 1'($urandom_range(1, 0));
                    pend[w].addr = pick_addr();
                    pend[w].wdata = $urandom();
                end
                set_req(w, has[w], pend[w].rw, pend[w].addr, pend[w].wdata);
            end
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("final_idle", busy, 0);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
